application_3: RTL and testbench

Single-digit hexadecimal counter demo for a common-anode 7-segment display. A prescaler divides the 50 MHz board clock into a count tick. A 4-bit counter advances 0→F→0 on each tick. The counter value is decoded to active-low segment drive, and the one digit is enabled through an active-low select. It is the top level of the one-digit display application and drives the board's segment, decimal-point and digit-select pins directly.

---
 rtl/application_3.sv | 60 ++++++
 tb/tb_application_3.sv | 111 +++++++++++
 2 files changed

// File: rtl/application_3.sv
// application_3: one-digit hex counter driving a common-anode 7-segment display.
// Define DP_BLINK_EN to blink the decimal point once per count step; otherwise dp stays off.
module application_3 #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       clk50MHz,
   input  logic       rst_n,
   output logic [6:0] Segments,
   output logic       dp,
   output logic       SEL7
);
   localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   logic [W-1:0] tick_cnt;
   logic [3:0]   digit;
   logic [6:0]   seg_nx;
   logic         tick;
   assign tick = tick_cnt == W'(TICK_DIV - 1);
   always_comb begin
      seg_nx = 7'h7F;
      case (digit)
         4'h0: seg_nx = 7'h40;
         4'h1: seg_nx = 7'h79;
         4'h2: seg_nx = 7'h24;
         4'h3: seg_nx = 7'h30;
         4'h4: seg_nx = 7'h19;
         4'h5: seg_nx = 7'h12;
         4'h6: seg_nx = 7'h02;
         4'h7: seg_nx = 7'h78;
         4'h8: seg_nx = 7'h00;
         4'h9: seg_nx = 7'h10;
         4'hA: seg_nx = 7'h08;
         4'hB: seg_nx = 7'h03;
         4'hC: seg_nx = 7'h46;
         4'hD: seg_nx = 7'h21;
         4'hE: seg_nx = 7'h06;
         4'hF: seg_nx = 7'h0E;
         default: seg_nx = 7'h7F;
      endcase
   end
   always_ff @(posedge clk50MHz) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         digit    <= '0;
         Segments <= 7'h7F;
         SEL7     <= 1'b1;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         digit    <= digit + 4'(tick);
         Segments <= seg_nx;
         SEL7     <= 1'b0;
      end
   end
`ifdef DP_BLINK_EN
   // Lit for the first half of each period, one cycle behind tick_cnt like Segments.
   always_ff @(posedge clk50MHz)
      dp <= !rst_n || (tick_cnt >= W'(TICK_DIV / 2));
`else
   assign dp = 1'b1;
`endif
endmodule

// File: tb/tb_application_3.sv
// tb_application_3: directed checks of the hex counter display with TICK_DIV=4 and TICK_DIV=5.
module tb_application_3;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] seg4, seg5;
   logic       dp4, dp5, sel4, sel5;
   int         total = 0;
   int         bad = 0;
   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   application_3 #(.TICK_DIV(4)) u4 (.clk50MHz(clk), .rst_n(rst_n), .Segments(seg4), .dp(dp4), .SEL7(sel4));
   application_3 #(.TICK_DIV(5)) u5 (.clk50MHz(clk), .rst_n(rst_n), .Segments(seg5), .dp(dp5), .SEL7(sel5));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_dp(input int n, input int div);
`ifdef DP_BLINK_EN
      return ((n - 1) % div) < (div / 2) ? 1'b0 : 1'b1;
`else
      return 1'b1;
`endif
   endfunction

   task automatic check_run4(input string name, input int n);
      logic [6:0] es;
      es = dec[((n - 1) / 4) % 16];
      total++;
      if (seg4 !== es || sel4 !== 1'b0 || dp4 !== exp_dp(n, 4)) begin
         bad++;
         $display("FAIL %s edge %0d: seg=%h sel=%b dp=%b, want seg=%h sel=0 dp=%b",
                  name, n, seg4, sel4, dp4, es, exp_dp(n, 4));
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (seg4 !== 7'h7F || dp4 !== 1'b1 || sel4 !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold edge %0d: seg=%h dp=%b sel=%b, want 7f 1 1", i, seg4, dp4, sel4);
         end
      end
   endtask

   task automatic test_sequence();
      rst_n = 1'b1;
      for (int n = 1; n <= 16 * 4 + 4; n++) begin
         step();
         check_run4("sequence", n);
      end
   endtask

   task automatic test_mid_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int n = 1; n <= 28; n++) step();
      step();
      total++;
      if (seg4 !== 7'h78) begin
         bad++;
         $display("FAIL pre_reset_digit7: seg=%h, want 78", seg4);
      end
      rst_n = 1'b0;
      step();
      total++;
      if (seg4 !== 7'h7F || dp4 !== 1'b1 || sel4 !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_blank: seg=%h dp=%b sel=%b, want 7f 1 1", seg4, dp4, sel4);
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         step();
         check_run4("after_mid_reset", n);
      end
   endtask

   task automatic test_odd_div();
      logic [6:0] es;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         step();
         es = dec[(n - 1) / 5];
         total++;
         if (seg5 !== es || sel5 !== 1'b0 || dp5 !== exp_dp(n, 5)) begin
            bad++;
            $display("FAIL odd_div edge %0d: seg=%h sel=%b dp=%b, want seg=%h sel=0 dp=%b",
                     n, seg5, sel5, dp5, es, exp_dp(n, 5));
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_mid_reset();
      test_odd_div();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
